// File: rtl/discrete_pkg.sv
// Shared types and constants for the discrete sound stages.
// Envelope states, LFSR geometry and phase increment helper.
package discrete_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    DECAY
  } env_state_t;

  localparam int LFSR_W     = 17;
  localparam int LFSR_TAP_A = 16;
  localparam int LFSR_TAP_B = 13;

  function automatic logic [31:0] phase_inc(
    input int unsigned freq,
    input int unsigned rate
  );
    logic [63:0] num;
    num = {32'd0, freq} << 32;
    return 32'(num / 64'(rate));
  endfunction

endpackage

// File: rtl/lfsr17.sv
// 17-bit Fibonacci LFSR, x^17 + x^14 + 1.
// Shifts left once per shift_en; feedback enters bit 0.
module lfsr17
  import discrete_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 17'h00001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              shift_en,
  output logic [LFSR_W-1:0] q
);

  // an all-zero seed would lock the register up
  localparam logic [LFSR_W-1:0] SEED_NZ =
    (SEED == '0) ? LFSR_W'(1) : SEED;

  logic fb;

  assign fb = q[LFSR_TAP_A] ^ q[LFSR_TAP_B];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED_NZ;
    end else if (shift_en) begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/envelope_noise_source.sv
// LFSR noise shaped by a triggered attack/decay envelope.
// Advances once per audio_clk_en; output lags the tick by one clk.
module envelope_noise_source
  import discrete_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE  = 48000,
  parameter int unsigned NOISE_FREQ   = 2000,
  parameter logic [15:0] AMPLITUDE    = 16'h3FFF,
  parameter int unsigned ATTACK_SHIFT = 4,
  parameter int unsigned DECAY_SHIFT  = 10,
  parameter logic [16:0] LFSR_SEED    = 17'h00001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        audio_clk_en,
  input  logic        trigger,
  output logic [31:0] out,
  output logic        busy
);

  localparam logic [31:0] INC = phase_inc(NOISE_FREQ, SAMPLE_RATE);

  logic              trig_d;
  logic              pending;
  logic              rise;
  logic              pend_eff;
  logic              tick_d;
  logic [31:0]       phase;
  logic [32:0]       phase_sum;
  logic              shift_en;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_unused;
  env_state_t        state;
  env_state_t        st_eff;
  env_state_t        state_n;
  logic [15:0]       env;
  logic [15:0]       env_n;
  logic [15:0]       atk;
  logic [15:0]       dec_raw;
  logic [15:0]       dec;
  logic [31:0]       prod;
  logic [31:0]       mag32;
  logic [31:0]       out_n;

  assign rise      = trigger & ~trig_d;
  assign pend_eff  = pending | rise;
  assign phase_sum = {1'b0, phase} + {1'b0, INC};
  assign shift_en  = audio_clk_en & phase_sum[32];

  lfsr17 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .shift_en(shift_en),
    .q       (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[LFSR_W-2:0];

  assign atk     = (16'hFFFF - env) >> ATTACK_SHIFT;
  assign dec_raw = env >> DECAY_SHIFT;
  assign dec     = (dec_raw == '0) ? 16'd1 : dec_raw;

  // a trigger restarts the attack from the current level
  always_comb begin
    st_eff  = pend_eff ? ATTACK : state;
    state_n = st_eff;
    env_n   = env;
    unique case (1'b1)
      (st_eff == ATTACK): begin
        if (atk == '0) begin
          env_n   = 16'hFFFF;
          state_n = DECAY;
        end else begin
          env_n = env + atk;
        end
      end
      (st_eff == DECAY): begin
        if (env <= dec) begin
          env_n   = '0;
          state_n = IDLE;
        end else begin
          env_n = env - dec;
        end
      end
      default: begin
        env_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign prod  = {16'd0, AMPLITUDE} * {16'd0, env};
  assign mag32 = prod >> 16;
  assign out_n = lfsr_q[LFSR_W-1] ? mag32 : (32'd0 - mag32);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_d  <= 1'b1;
      pending <= 1'b0;
      tick_d  <= 1'b0;
      phase   <= '0;
      state   <= IDLE;
      env     <= '0;
      out     <= '0;
      busy    <= 1'b0;
    end else begin
      trig_d <= trigger;
      tick_d <= audio_clk_en;
      if (audio_clk_en) begin
        pending <= 1'b0;
        phase   <= phase_sum[31:0];
        state   <= state_n;
        env     <= env_n;
      end else if (rise) begin
        pending <= 1'b1;
      end
      if (tick_d) begin
        out  <= out_n;
        busy <= (state != IDLE);
      end
    end
  end

endmodule
